// File: rtl/hist53b_seq_ctrl.sv
// Run sequencer for the 53B hit histogrammer: clear bins, accumulate a
// programmed number of frames, then drain and stream every bin out.
module hist53b_seq_ctrl #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 16,
    parameter int RD_LATENCY   = 2,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                             USER_CLK,
    input  logic                             USER_RST_N,
    input  logic                             CMD_START,
    input  logic                             CMD_ABORT,
    input  logic [31:0]                      FRAME_LIMIT,
    input  logic                             FRAME_TICK,
    output logic                             HIST_EN,
    output logic [ADDR_WIDTH-1:0]            MEM_ADDR,
    output logic                             MEM_WE,
    output logic [DATA_WIDTH-1:0]            MEM_WDATA,
    output logic                             MEM_RE,
    input  logic [DATA_WIDTH-1:0]            MEM_RDATA,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] OUT_DATA,
    output logic                             OUT_VALID,
    input  logic                             OUT_READY,
    output logic                             BUSY,
    output logic                             DONE,
    output logic [31:0]                      FRAME_CNT
);

    localparam int NBINS = 2 ** ADDR_WIDTH;
    localparam int CW    = 16;

    localparam logic [ADDR_WIDTH:0] ADDR_LAST  = (ADDR_WIDTH + 1)'(NBINS - 1);
    localparam logic [ADDR_WIDTH:0] ADDR_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [CW-1:0]       DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0]       RD_LAST    = CW'(RD_LATENCY - 1);
    localparam logic [CW-1:0]       WAIT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_OUT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH:0]                addr_q, addr_d;
    logic [CW-1:0]                      wait_q, wait_d;
    logic [31:0]                        limit_q, limit_d;
    logic [31:0]                        cnt_q, cnt_d;
    logic                               hist_en_q, hist_en_d;
    logic                               out_valid_q, out_valid_d;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0]   out_data_q, out_data_d;

    always_ff @(posedge USER_CLK) begin
        if (!USER_RST_N) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wait_q      <= '0;
            limit_q     <= '0;
            cnt_q       <= '0;
            hist_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wait_q      <= wait_d;
            limit_q     <= limit_d;
            cnt_q       <= cnt_d;
            hist_en_q   <= hist_en_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wait_d      = wait_q;
        limit_d     = limit_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (CMD_START) begin
                    limit_d = FRAME_LIMIT;
                    cnt_d   = '0;
                    addr_d  = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (addr_q == ADDR_LAST) begin
                    addr_d  = '0;
                    state_d = S_RUN;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_RUN: begin
                // A zero limit still spends one cycle accumulating
                if (limit_q == '0) begin
                    wait_d  = '0;
                    state_d = S_DRAIN;
                end else if (FRAME_TICK) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 32'd1;
                    end
                    if (cnt_d == limit_q) begin
                        wait_d  = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (wait_q == DRAIN_LAST) begin
                    state_d = S_RD_ISSUE;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            S_RD_ISSUE: begin
                wait_d  = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wait_q == RD_LAST) begin
                    out_data_d  = {addr_q[ADDR_WIDTH-1:0], MEM_RDATA};
                    out_valid_d = 1'b1;
                    state_d     = S_RD_OUT;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            S_RD_OUT: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    if (addr_q == ADDR_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort beats a same-cycle start and keeps the frame count
        if (CMD_ABORT) begin
            state_d     = S_IDLE;
            addr_d      = addr_q;
            limit_d     = limit_q;
            cnt_d       = cnt_q;
            out_valid_d = 1'b0;
        end

        hist_en_d = (state_d == S_RUN);
    end

    assign HIST_EN   = hist_en_q;
    assign MEM_ADDR  = addr_q[ADDR_WIDTH-1:0];
    assign MEM_WE    = (state_q == S_CLEAR);
    assign MEM_WDATA = '0;
    assign MEM_RE    = (state_q == S_RD_ISSUE);
    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign BUSY      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign DONE      = (state_q == S_DONE);
    assign FRAME_CNT = cnt_q;

endmodule

// File: doc/hist53b_seq_ctrl.md
Name: hist53b_seq_ctrl

Overview:
- Run sequencer for the 53B hit histogrammer, in the USER_CLK domain beside the histogram core.
- Sequences one histogram run: zero the bin RAM, enable accumulation for a programmed number of Aurora frames, then drain and read out every bin as a ready/valid stream.
- Owns the bin-RAM port outside the RUN state; owns the accumulator enable at all times.

Parameters:
- ADDR_WIDTH, 12, bin-RAM address width; NBINS = 2**ADDR_WIDTH.
- DATA_WIDTH, 16, bin counter width.
- RD_LATENCY, 2, bin-RAM read latency in cycles (>=1).
- DRAIN_CYCLES, 8, idle cycles after HIST_EN falls before readout; covers the accumulator pipeline.

Ports:
- USER_CLK  in  1  only clock; all logic on rising edge.
- USER_RST_N  in  1  synchronous, active-low reset.
- CMD_START  in  1  single-cycle pulse; starts a run when IDLE or DONE.
- CMD_ABORT  in  1  single-cycle pulse; returns to IDLE from any state.
- FRAME_LIMIT  in  32  frames to accumulate; sampled on accepted CMD_START.
- FRAME_TICK  in  1  one pulse per valid Aurora frame (AURORA_RX_TVALID qualified).
- HIST_EN  out  1  accumulator enable to the histogram core.
- MEM_ADDR  out  ADDR_WIDTH  bin-RAM address.
- MEM_WE  out  1  bin-RAM write strobe.
- MEM_WDATA  out  DATA_WIDTH  bin-RAM write data; always 0.
- MEM_RE  out  1  bin-RAM read strobe.
- MEM_RDATA  in  DATA_WIDTH  read data, valid RD_LATENCY cycles after MEM_RE.
- OUT_DATA  out  ADDR_WIDTH+DATA_WIDTH  {bin address, count}.
- OUT_VALID  out  1  stream valid.
- OUT_READY  in  1  stream ready.
- BUSY  out  1  high in every state except IDLE and DONE.
- DONE  out  1  high in the DONE state.
- FRAME_CNT  out  32  frames counted in the current or last run.

Behaviour:
- Reset (USER_RST_N=0 at an edge): state IDLE. All outputs 0, including MEM_ADDR, OUT_DATA and FRAME_CNT. Overrides all commands in the same cycle.
- States: IDLE, CLEAR, RUN, DRAIN, RD_ISSUE, RD_WAIT, RD_OUT, DONE.
- IDLE/DONE, on CMD_START:
  - latch FRAME_LIMIT; FRAME_CNT<=0; addr<=0; go to CLEAR.
  - CMD_START in any other state is ignored.
- CLEAR:
  - MEM_WE=1, MEM_WDATA=0, MEM_ADDR=addr; addr increments each cycle.
  - Exactly NBINS write cycles; on addr=NBINS-1, go to RUN with addr<=0.
- RUN:
  - HIST_EN=1 is registered and asserts on the first RUN cycle. MEM_WE=MEM_RE=0.
  - Each FRAME_TICK increments FRAME_CNT. The tick that makes FRAME_CNT equal the latched limit moves to DRAIN; HIST_EN drops the next cycle.
  - Limit 0: RUN lasts exactly one cycle, then DRAIN; FRAME_CNT stays 0.
  - Ticks outside RUN are not counted.
- DRAIN: HIST_EN=0; DRAIN_CYCLES cycles, then RD_ISSUE.
- RD_ISSUE: MEM_RE=1 for one cycle at MEM_ADDR=addr; go to RD_WAIT.
- RD_WAIT:
  - Wait RD_LATENCY cycles from MEM_RE, then capture {addr, MEM_RDATA} into OUT_DATA; OUT_VALID<=1; go to RD_OUT.
- RD_OUT:
  - OUT_DATA is held stable while OUT_VALID=1 && OUT_READY=0.
  - On handshake (valid && ready):
    - if addr=NBINS-1, OUT_VALID<=0 and go to DONE;
    - else addr++, OUT_VALID<=0, go to RD_ISSUE.
  - One outstanding read only; peak rate is one beat per RD_LATENCY+2 cycles.
- DONE: FRAME_CNT holds; DONE=1 until CMD_START, CMD_ABORT or reset.
- CMD_ABORT:
  - Next state IDLE. HIST_EN, MEM_WE, MEM_RE and OUT_VALID go to 0 on the next edge. FRAME_CNT is kept.
  - A beat in flight is dropped even if OUT_READY is high that cycle.
  - CMD_START and CMD_ABORT in the same cycle: ABORT wins.
- Address counter: ADDR_WIDTH+1 bits internally; no wrap past NBINS-1.
- FRAME_CNT saturates at 2**32-1.
- The block never drives MEM_WE and MEM_RE in the same cycle.

Test Plan:
- Reset, then CMD_START with FRAME_LIMIT=3, ADDR_WIDTH=4 -> 16 MEM_WE cycles (addr 0..15, data 0), then HIST_EN=1.
- 3 FRAME_TICKs in RUN -> FRAME_CNT=3, HIST_EN low, DRAIN 8 cycles, then 16 beats with address field 0..15 in order; then DONE=1, BUSY=0.
- OUT_READY held low 10 cycles on beat 5 -> OUT_DATA stable for all 10 cycles; no beat lost or duplicated; beat 6 follows.
- Preload RAM model bin 7=0x1234 after CLEAR -> beat 7 OUT_DATA={4'h7,16'h1234}.
- FRAME_LIMIT=0 -> RUN lasts 1 cycle, FRAME_CNT=0, readout completes normally.
- CMD_ABORT during RD_OUT with OUT_VALID=1 -> IDLE next cycle, OUT_VALID=0, BUSY=0.
- CMD_START+CMD_ABORT same cycle in DONE -> IDLE.
- USER_RST_N low mid-CLEAR -> all outputs 0 on the next edge.
